// File: rtl/slot_pkg.sv
// Shared types and constants for the slot machine credit display path.
package slot_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int CREDIT_BIN_W  = 12;
  localparam int CREDIT_DIGITS = 3;
  localparam int CREDIT_SAT    = 999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD nibble: add 3 when the digit is 5 or more.
module bcd_digit_adj
  import slot_pkg::*;
(
  input  bcd_digit_t digit,
  output bcd_digit_t adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/credit_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with saturation to the largest displayable value and an overflow flag.
module credit_bcd_converter
  import slot_pkg::*;
#(
  parameter int BIN_W   = CREDIT_BIN_W,
  parameter int DIGITS  = CREDIT_DIGITS,
  parameter int SAT_VAL = CREDIT_SAT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  // One guard digit above the displayed ones so large inputs do not wrap mid-conversion.
  localparam int ACC_W = 4*DIGITS + 4;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W:0]      SAT_EXT = (BIN_W+1)'(SAT_VAL);
  localparam logic [4*DIGITS-1:0] NINES   = {DIGITS{4'h9}};

  conv_state_t            state;
  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       acc_adj;
  logic [BIN_W-1:0]       shreg;
  logic [CNT_W-1:0]       cnt;
  logic                   ovf_pending;
  logic [ACC_W+BIN_W-1:0] shifted;

  for (genvar g = 0; g < DIGITS + 1; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (acc[4*g +: 4]),
      .adjusted (acc_adj[4*g +: 4])
    );
  end

  // Adjust first, then shift the combined {acc, shreg} left by one bit.
  assign shifted = {acc_adj[ACC_W-2:0], shreg, 1'b0};

  assign busy = (state != IDLE);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, exactly like the hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      shreg       <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      valid       <= 1'b0;
      bcd_out     <= '0;
      overflow    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg       <= bin_in;
            acc         <= '0;
            cnt         <= CNT_W'(BIN_W);
            ovf_pending <= ({1'b0, bin_in} > SAT_EXT);
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          acc   <= shifted[ACC_W+BIN_W-1:BIN_W];
          shreg <= shifted[BIN_W-1:0];
          cnt   <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          // Outputs change only here, so they never show a half-finished value.
          if (ovf_pending) begin
            bcd_out  <= NINES;
            overflow <= 1'b1;
          end else begin
            bcd_out  <= acc[4*DIGITS-1:0];
            overflow <= 1'b0;
          end
          valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
